multiplier8_seq: RTL

Sequential 8×8 shift-add multiplier for the processor's arithmetic unit, the iterative counterpart of the 8-bit signed divider. It covers byte MUL/IMUL: unsigned or two's-complement operands produce a 16-bit product (AH:AL) and an upper-half-significant flag that feeds CF/OF. A result is produced 9 cycles after a start is accepted.

---
 rtl/multiplier8_seq_if.sv | 22 ++
 rtl/multiplier8_seq.sv | 104 ++++++++++
 2 files changed

// File: rtl/multiplier8_seq_if.sv
// Handshake and data bundle for the sequential 8x8 multiplier.
// The master issues start/operands; the slave returns busy/done/product/ovf.
interface multiplier8_seq_if;
   logic        start;
   logic        is_signed;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        ovf;

   modport master (
      output start, is_signed, multiplicand, multiplier,
      input  busy, done, product, ovf
   );

   modport slave (
      input  start, is_signed, multiplicand, multiplier,
      output busy, done, product, ovf
   );
endinterface

// File: rtl/multiplier8_seq.sv
// Sequential 8x8 shift-add multiplier for byte MUL/IMUL.
// Operates on magnitudes and negates at the end; ovf flags a significant upper half.
//
//   state  | meaning
//   S_IDLE | waiting for start
//   S_CALC | 8 shift-add iterations, then one cycle to finalize
//   S_DONE | result valid for one cycle, start accepted here
module multiplier8_seq (
   input  logic                   clk,
   input  logic                   rst_n,
   multiplier8_seq_if.slave       bus
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic        r_fin;
   logic [7:0]  r_mag_a;
   logic [7:0]  r_mag_b;
   logic [15:0] r_acc;
   logic        r_neg;
   logic        r_is_signed;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_product;
   logic        r_ovf;

   logic [7:0]  w_mag_a;
   logic [7:0]  w_mag_b;
   logic [15:0] w_addend;
   logic [15:0] w_prod;
   logic        w_ovf;

   always_comb begin
      w_mag_a  = (bus.is_signed && bus.multiplicand[7]) ? (8'd0 - bus.multiplicand)
                                                        : bus.multiplicand;
      w_mag_b  = (bus.is_signed && bus.multiplier[7]) ? (8'd0 - bus.multiplier)
                                                      : bus.multiplier;
      w_addend = {8'd0, r_mag_a} << r_cnt;
      w_prod   = r_neg ? (16'd0 - r_acc) : r_acc;
      w_ovf    = r_is_signed ? (w_prod[15:8] != {8{w_prod[7]}})
                             : (w_prod[15:8] != 8'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_fin       <= 1'b0;
         r_mag_a     <= 8'd0;
         r_mag_b     <= 8'd0;
         r_acc       <= 16'd0;
         r_neg       <= 1'b0;
         r_is_signed <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_product   <= 16'd0;
         r_ovf       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_state     <= S_CALC;
                  r_busy      <= 1'b1;
                  r_is_signed <= bus.is_signed;
                  r_mag_a     <= w_mag_a;
                  r_mag_b     <= w_mag_b;
                  r_neg       <= bus.is_signed & (bus.multiplicand[7] ^ bus.multiplier[7]);
                  r_acc       <= 16'd0;
                  r_cnt       <= 3'd0;
                  r_fin       <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CALC: begin
               // r_fin marks the extra cycle after the 8th iteration, since the counter wraps
               if (r_fin) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_product <= w_prod;
                  r_ovf     <= w_ovf;
                  r_fin     <= 1'b0;
               end else begin
                  if (r_mag_b[0])
                     r_acc <= r_acc + w_addend;
                  r_mag_b <= r_mag_b >> 1;
                  r_cnt   <= r_cnt + 3'd1;
                  if (r_cnt == 3'd7)
                     r_fin <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;
   assign bus.ovf     = r_ovf;
endmodule
